// File: rtl/i2c_control_queue.sv
// Purpose: DEPTH-entry descriptor queue between the APB register file and the I2C master FSM.
// Latency: a load_next moves the queue head into the active registers at the next edge; loaded pulses with it.
// Backpressure: a push into a full queue is dropped and flagged (overflow) unless a load frees a slot the same cycle.
// Optional feature: I2C_CTRLQ_DIV_CLAMP_EN raises pushed dividers below MIN_CLOCK_DIV to MIN_CLOCK_DIV.
module i2c_control_queue #(
    parameter int DEPTH           = 4,
    parameter int ADDR_W          = 10,
    parameter int DIV_W           = 32,
    parameter int RESET_CLOCK_DIV = 300,
    parameter int MIN_CLOCK_DIV   = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          u_bus_address,
    input  logic                       u_data_direction,
    input  logic                       u_address_mode,
    input  logic                       u_stretch_enabled,
    input  logic [DIV_W-1:0]           u_clock_div,
    input  logic                       load_next,
    input  logic                       flush,
    output logic [ADDR_W-1:0]          bus_address,
    output logic                       data_direction,
    output logic                       address_mode,
    output logic                       stretch_enabled,
    output logic [DIV_W-1:0]           clock_div,
    output logic                       loaded,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] bus_address;
        logic              data_direction;
        logic              address_mode;
        logic              stretch_enabled;
        logic [DIV_W-1:0]  clock_div;
    } desc_t;

    desc_t             mem [DEPTH];
    desc_t             wr_desc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_load;
    logic              overflow_nxt;
    logic              underflow_nxt;
    logic [CNT_W-1:0]  count_nxt;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Build the descriptor to store, applying the optional divider floor
    always_comb begin
        wr_desc.bus_address     = u_bus_address;
        wr_desc.data_direction  = u_data_direction;
        wr_desc.address_mode    = u_address_mode;
        wr_desc.stretch_enabled = u_stretch_enabled;
`ifdef I2C_CTRLQ_DIV_CLAMP_EN
        wr_desc.clock_div = (u_clock_div < DIV_W'(MIN_CLOCK_DIV)) ? DIV_W'(MIN_CLOCK_DIV) : u_clock_div;
`else
        wr_desc.clock_div = u_clock_div;
`endif
    end

    // Decide which operations take effect; flush masks everything, a load frees a slot for a same-cycle push
    always_comb begin
        do_load       = load_next && !flush && !empty;
        do_push       = push && !flush && (!full || do_load);
        overflow_nxt  = push && !flush && full && !do_load;
        underflow_nxt = load_next && !flush && empty;
        count_nxt     = count;
        if (flush) begin
            count_nxt = '0;
        end else if (do_push && !do_load) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_load && !do_push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Descriptor storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_desc;
        end
    end

    // Pointers, occupancy and status pulses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            loaded    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_nxt;
            loaded    <= do_load;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_load) rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Active descriptor registers change only on a successful load
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_address     <= '0;
            data_direction  <= 1'b0;
            address_mode    <= 1'b0;
            stretch_enabled <= 1'b1;
            clock_div       <= DIV_W'(RESET_CLOCK_DIV);
        end else if (do_load) begin
            bus_address     <= mem[rd_ptr].bus_address;
            data_direction  <= mem[rd_ptr].data_direction;
            address_mode    <= mem[rd_ptr].address_mode;
            stretch_enabled <= mem[rd_ptr].stretch_enabled;
            clock_div       <= mem[rd_ptr].clock_div;
        end
    end

endmodule

// File: tb/tb_i2c_control_queue.sv
// Directed bench for i2c_control_queue with DEPTH=4 and default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point after each edge.
module tb_i2c_control_queue;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        push;
    logic [9:0]  u_bus_address;
    logic        u_data_direction;
    logic        u_address_mode;
    logic        u_stretch_enabled;
    logic [31:0] u_clock_div;
    logic        load_next;
    logic        flush;
    logic [9:0]  bus_address;
    logic        data_direction;
    logic        address_mode;
    logic        stretch_enabled;
    logic [31:0] clock_div;
    logic        loaded;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;

    int vectors     = 0;
    int miscompares = 0;

    i2c_control_queue dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .push             (push),
        .u_bus_address    (u_bus_address),
        .u_data_direction (u_data_direction),
        .u_address_mode   (u_address_mode),
        .u_stretch_enabled(u_stretch_enabled),
        .u_clock_div      (u_clock_div),
        .load_next        (load_next),
        .flush            (flush),
        .bus_address      (bus_address),
        .data_direction   (data_direction),
        .address_mode     (address_mode),
        .stretch_enabled  (stretch_enabled),
        .clock_div        (clock_div),
        .loaded           (loaded),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input logic [9:0] a, input logic d, input logic m, input logic s, input logic [31:0] dv);
        u_bus_address     = a;
        u_data_direction  = d;
        u_address_mode    = m;
        u_stretch_enabled = s;
        u_clock_div       = dv;
    endtask

    task automatic do_push(input logic [9:0] a, input logic d, input logic m, input logic s, input logic [31:0] dv);
        set_desc(a, d, m, s, dv);
        push = 1'b1;
        step();
        push = 1'b0;
    endtask

    task automatic do_load();
        load_next = 1'b1;
        step();
        load_next = 1'b0;
    endtask

    initial begin
        n_rst     = 1'b0;
        push      = 1'b0;
        load_next = 1'b0;
        flush     = 1'b0;
        set_desc(10'h0, 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        step();

        // 1: reset values
        chk("rst_addr",    bus_address, 64'h0);
        chk("rst_dir",     data_direction, 64'd0);
        chk("rst_mode",    address_mode, 64'd0);
        chk("rst_stretch", stretch_enabled, 64'd1);
        chk("rst_div",     clock_div, 64'd300);
        chk("rst_empty",   empty, 64'd1);
        chk("rst_full",    full, 64'd0);
        chk("rst_count",   count, 64'd0);
        chk("rst_flags",   {loaded, overflow, underflow}, 64'd0);
        n_rst = 1'b1;
        step();

        // 2: two descriptors, loaded in order
        do_push(10'h050, 1'b1, 1'b0, 1'b1, 32'd100);
        chk("t2_count1", count, 64'd1);
        chk("t2_empty0", empty, 64'd0);
        do_push(10'h3A5, 1'b0, 1'b1, 1'b0, 32'd200);
        chk("t2_count2", count, 64'd2);
        do_load();
        chk("t2_loadedA", loaded, 64'd1);
        chk("t2_A", {bus_address, data_direction, address_mode, stretch_enabled, clock_div},
            {10'h050, 1'b1, 1'b0, 1'b1, 32'd100});
        chk("t2_countA", count, 64'd1);
        step();
        chk("t2_loaded_drop", loaded, 64'd0);
        chk("t2_hold", bus_address, 64'h050);
        do_load();
        chk("t2_loadedB", loaded, 64'd1);
        chk("t2_B", {bus_address, data_direction, address_mode, stretch_enabled, clock_div},
            {10'h3A5, 1'b0, 1'b1, 1'b0, 32'd200});
        chk("t2_countB", count, 64'd0);
        chk("t2_emptyB", empty, 64'd1);

        // 3: overfill by one, then drain in order
        for (int i = 1; i <= 4; i++) do_push(10'(i), 1'b0, 1'b0, 1'b1, 32'(10 + i));
        chk("t3_full",  full, 64'd1);
        chk("t3_count", count, 64'd4);
        chk("t3_no_ovf", overflow, 64'd0);
        do_push(10'd5, 1'b1, 1'b1, 1'b1, 32'd15);
        chk("t3_ovf",   overflow, 64'd1);
        chk("t3_count_hold", count, 64'd4);
        step();
        chk("t3_ovf_drop", overflow, 64'd0);
        for (int i = 1; i <= 4; i++) begin
            do_load();
            chk("t3_drain_addr", bus_address, 64'(i));
            chk("t3_drain_div",  clock_div, 64'(10 + i));
        end
        chk("t3_empty", empty, 64'd1);

        // 4: underflow, then push+load on empty
        do_load();
        chk("t4_udf",    underflow, 64'd1);
        chk("t4_noload", loaded, 64'd0);
        chk("t4_hold",   bus_address, 64'd4);
        set_desc(10'h007, 1'b1, 1'b0, 1'b1, 32'd77);
        push = 1'b1; load_next = 1'b1;
        step();
        push = 1'b0; load_next = 1'b0;
        chk("t4_udf2",   underflow, 64'd1);
        chk("t4_count1", count, 64'd1);
        chk("t4_hold2",  bus_address, 64'd4);
        do_load();
        chk("t4_stored", {bus_address, clock_div}, {10'h007, 32'd77});
        chk("t4_udf_drop", underflow, 64'd0);

        // 5: push+load on full, flush, then wrap-around order
        for (int i = 0; i < 4; i++) do_push(10'(16 + i), 1'b0, 1'b0, 1'b1, 32'(50 + i));
        set_desc(10'h014, 1'b0, 1'b0, 1'b1, 32'd54);
        push = 1'b1; load_next = 1'b1;
        step();
        push = 1'b0; load_next = 1'b0;
        chk("t5_count4", count, 64'd4);
        chk("t5_no_ovf", overflow, 64'd0);
        chk("t5_loaded", loaded, 64'd1);
        chk("t5_head",   bus_address, 64'h010);
        push = 1'b1; load_next = 1'b1; flush = 1'b1;
        step();
        push = 1'b0; load_next = 1'b0; flush = 1'b0;
        chk("t5_flush_count", count, 64'd0);
        chk("t5_flush_empty", empty, 64'd1);
        chk("t5_flush_flags", {loaded, overflow, underflow}, 64'd0);
        chk("t5_flush_active", {bus_address, clock_div}, {10'h010, 32'd50});
        for (int i = 0; i < 10; i++) begin
            do_push(10'(256 + i), 1'(i & 1), 1'b0, 1'b1, 32'(1000 + i));
            do_load();
            chk("t5_wrap", {bus_address, data_direction, clock_div}, {10'(256 + i), 1'(i & 1), 32'(1000 + i)});
        end
        chk("t5_wrap_empty", empty, 64'd1);

        // 6: divider below the floor
        do_push(10'h011, 1'b0, 1'b0, 1'b1, 32'd1);
        do_load();
`ifdef I2C_CTRLQ_DIV_CLAMP_EN
        chk("t6_div", clock_div, 64'd4);
`else
        chk("t6_div", clock_div, 64'd1);
`endif
        chk("t6_addr", bus_address, 64'h011);

        // Reset mid-operation discards queued entries
        do_push(10'h022, 1'b1, 1'b1, 1'b0, 32'd9);
        n_rst = 1'b0;
        #2;
        chk("t7_rst_count", count, 64'd0);
        chk("t7_rst_div",   clock_div, 64'd300);
        step();
        n_rst = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
